// File: rtl/seg_pkg.sv
// Seven-segment pattern constants, digit indices and shared decode helpers.
`timescale 1ns/1ps
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       invalid;
  } seg_dec_t;

  typedef enum logic {TRACK = 1'b0, HELD = 1'b1} stab_state_t;

  function automatic seg_dec_t seg_to_bcd(input logic [6:0] seg);
    seg_dec_t d;
    d.value   = 4'hF;
    d.blank   = 1'b0;
    d.invalid = 1'b0;
    case (seg)
      SEG_0:     d.value = 4'd0;
      SEG_1:     d.value = 4'd1;
      SEG_2:     d.value = 4'd2;
      SEG_3:     d.value = 4'd3;
      SEG_4:     d.value = 4'd4;
      SEG_5:     d.value = 4'd5;
      SEG_6:     d.value = 4'd6;
      SEG_7:     d.value = 4'd7;
      SEG_8:     d.value = 4'd8;
      SEG_9:     d.value = 4'd9;
      SEG_BLANK: begin
        d.value = 4'd0;
        d.blank = 1'b1;
      end
      default:   d.invalid = 1'b1;
    endcase
    return d;
  endfunction

  // Exactly one anode driven low selects a digit; idle and multi-drive are rejected.
  function automatic logic anode_legal(input logic [3:0] an);
    return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
  endfunction

  function automatic logic [1:0] anode_to_idx(input logic [3:0] an);
    logic [1:0] idx;
    case (an)
      4'b0111: idx = DIG_MIN_TENS;
      4'b1011: idx = DIG_MIN_ONES;
      4'b1101: idx = DIG_SEC_TENS;
      default: idx = DIG_SEC_ONES;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational active-low segment pattern to BCD decoder with blank/invalid flags.
`timescale 1ns/1ps
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       blank,
  output logic       invalid
);

  seg_dec_t dec;

  always_comb begin
    dec = seg_to_bcd(seg);
  end

  assign value   = dec.value;
  assign blank   = dec.blank;
  assign invalid = dec.invalid;

endmodule

// File: rtl/seven_seg_capture.sv
// Debounces a multiplexed 4-digit seven-segment scan and publishes decoded mm:ss frames.
// Optional MMSS_RANGE_CHECK_EN adds rangeErr (tens digits above 5 or any invalid digit).
`timescale 1ns/1ps
module seven_seg_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [3:0]  boardAnode,
  input  logic [6:0]  segmentLed,
  output logic [15:0] digits,
  output logic [3:0]  blankMask,
  output logic [3:0]  invalidMask,
  output logic        frameValid,
  output logic        digitStrobe,
  output logic [1:0]  digitIdx,
`ifdef MMSS_RANGE_CHECK_EN
  output logic        rangeErr,
`endif
  output logic        scanStall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  logic [3:0]       s_anode;
  logic [6:0]       s_seg;
  stab_state_t      state, state_nxt;
  logic [CNT_W-1:0] stab_cnt, stab_cnt_nxt;
  logic             same, accept;
  logic [1:0]       acc_idx;
  logic [3:0]       acc_bit;
  logic [3:0]       dec_value;
  logic             dec_blank, dec_invalid;
  logic [3:0][3:0]  sh_val;
  logic [3:0]       sh_blank, sh_inv, cap_mask;
  logic             frame_done;
  logic [TO_W-1:0]  to_cnt;

  seg_decode u_decode (
    .seg     (s_seg),
    .value   (dec_value),
    .blank   (dec_blank),
    .invalid (dec_invalid)
  );

  // The incoming sample is compared against S, so the count reflects how long S has held.
  assign same       = (boardAnode == s_anode) && (segmentLed == s_seg);
  assign accept     = (state == TRACK) && (stab_cnt == CNT_LAST) && anode_legal(s_anode);
  assign acc_idx    = anode_to_idx(s_anode);
  assign acc_bit    = accept ? (4'b0001 << acc_idx) : 4'b0000;
  assign frame_done = (cap_mask == 4'hF);
  assign scanStall  = (to_cnt == TO_MAX);

  always_comb begin
    state_nxt    = state;
    stab_cnt_nxt = '0;
    if (!same) begin
      state_nxt = TRACK;
    end else if (accept) begin
      state_nxt = HELD;
    end else if (state == TRACK && anode_legal(boardAnode) && stab_cnt != CNT_LAST) begin
      stab_cnt_nxt = stab_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s_anode     <= '0;
      s_seg       <= '0;
      state       <= TRACK;
      stab_cnt    <= '0;
      digitStrobe <= 1'b0;
      digitIdx    <= '0;
    end else begin
      s_anode     <= boardAnode;
      s_seg       <= segmentLed;
      state       <= state_nxt;
      stab_cnt    <= stab_cnt_nxt;
      digitStrobe <= accept;
      if (accept) digitIdx <= acc_idx;
    end
  end

  // A digit accepted while the full mask is being retired seeds the next frame.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sh_val      <= '0;
      sh_blank    <= '0;
      sh_inv      <= '0;
      cap_mask    <= '0;
      digits      <= '0;
      blankMask   <= '0;
      invalidMask <= '0;
      frameValid  <= 1'b0;
    end else begin
      if (accept) begin
        sh_val[acc_idx]   <= dec_value;
        sh_blank[acc_idx] <= dec_blank;
        sh_inv[acc_idx]   <= dec_invalid;
      end
      cap_mask   <= frame_done ? acc_bit : (cap_mask | acc_bit);
      frameValid <= frame_done;
      if (frame_done) begin
        digits      <= sh_val;
        blankMask   <= sh_blank;
        invalidMask <= sh_inv;
      end
    end
  end

`ifdef MMSS_RANGE_CHECK_EN
  logic range_bad;
  // Blank tens digits are exempt so an adjust-mode blink is not flagged.
  assign range_bad = (|sh_inv)
                   || (sh_val[DIG_SEC_TENS] > 4'd5 && !sh_blank[DIG_SEC_TENS])
                   || (sh_val[DIG_MIN_TENS] > 4'd5 && !sh_blank[DIG_MIN_TENS]);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rangeErr <= 1'b0;
    end else if (frame_done) begin
      rangeErr <= range_bad;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule
